// File: rtl/seq_mult_ctrl_if.sv
// rtl/seq_mult_ctrl_if.sv - requester-side handshake bundle for seq_mult_ctrl
//
// Purpose: groups the start/operand request and busy/done/product response
// of the sequential multiplier so requester and controller share one port.
// Signals:
//   start   requester -> controller  request, sampled only while idle
//   a, b    requester -> controller  WIDTH-bit multiplicand / multiplier
//   busy    controller -> requester  high while iterating
//   done    controller -> requester  one-cycle pulse, product valid
//   product controller -> requester  2*WIDTH-bit held result
// Modports: master = requester, slave = controller.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - sequential unsigned shift-and-add multiplier controller
//
// Purpose: forms a 2*WIDTH-bit unsigned product by reusing one WIDTH-bit adder
// over WIDTH iterations. IDLE accepts a start and latches the operands, RUN
// performs one add/shift step per clock, DONE presents the result for a
// single cycle before returning to IDLE.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation in flight)
//   bus    seq_mult_ctrl_if.slave: start/a/b in, busy/done/product out
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   acc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   q_shift;
  logic               last;
  logic               load;
  logic               step;

  // One iteration: conditional add into {carry, acc}, then shift {carry, acc, q}
  // right by one. The carry lands in acc's MSB, so it is never held across
  // steps and needs no register of its own.
  always_comb begin
    sum       = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    acc_shift = sum[WIDTH:1];
    q_shift   = {sum[0], q[WIDTH-1:1]};
  end

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      m     <= bus.a;
      q     <= bus.b;
      acc   <= '0;
      count <= '0;
    end else if (step) begin
      acc   <= acc_shift;
      q     <= q_shift;
      count <= count + CW'(1);
      // product only moves on the final step and holds through later runs
      if (last) begin
        product <= {acc_shift, q_shift};
      end
    end
  end

  assign bus.busy    = (state == S_RUN);
  assign bus.done    = (state == S_DONE);
  assign bus.product = product;
endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequential unsigned shift-and-add multiplier controller.
- Reuses one WIDTH-bit adder over WIDTH iterations to form a 2*WIDTH-bit product.
- Sits between a requester (start/operands) and the shared ripple-carry adder datapath.
- Sequences loading, iterative add/shift and result handoff with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; iteration counter is clog2(WIDTH)+1 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand; latched on accepted start
b  input  WIDTH  multiplier; latched on accepted start
busy  output  1  high while an operation is in progress (states RUN)
done  output  1  one-cycle pulse when product is valid
product  output  2*WIDTH  result register; holds until next completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, product=0; internal M, Q, ACC, C, count all 0.
  - Reset mid-operation aborts it; no done is generated.
- Internal registers: M[WIDTH] multiplicand, Q[WIDTH] multiplier/low half, ACC[WIDTH] high half, C carry, count.
- States:
  - IDLE:
    - busy=0.
    - On an edge with start=1: M<=a, Q<=b, ACC<=0, C<=0, count<=0, go to RUN.
    - start=0: stay in IDLE.
  - RUN:
    - busy=1.
    - Each edge executes one step:
      - If Q[0]=1: {C,ACC} = ACC + M (WIDTH+1-bit sum, carry-out into C).
      - Else: {C,ACC} = {0,ACC}.
      - Then right shift {C,ACC,Q} by 1 in the same edge: new ACC={C,ACC[WIDTH-1:1]}, new Q={ACC[0],Q[WIDTH-1:1]}, C cleared.
      - count<=count+1.
    - At the edge where count==WIDTH-1 (the WIDTH-th step): product<={new ACC,new Q}, done<=1, go to DONE.
  - DONE:
    - busy=0, done=1 for exactly this cycle.
    - Next edge: done<=0, go to IDLE.
    - start is ignored in DONE.
- Start handling:
  - start is ignored while busy or in DONE; there is no queuing.
  - Holding start high re-triggers on the first IDLE cycle after DONE.
- Operand stability: a and b may change freely after the accepting edge; only the latched copies are used.
- Latency: start accepted at edge E0; steps occur at edges E1..E_WIDTH; done is high during the cycle following E_WIDTH. Throughput is one result per WIDTH+2 cycles.
- product updates only at completion and holds its value through IDLE, RUN and DONE of later operations until the next completion.
- Arithmetic:
  - Unsigned only; no overflow is possible (2*WIDTH-bit result).
  - Carry-out of every add is captured; none is dropped.
- Edge cases:
  - a=0 or b=0 still takes the full WIDTH steps and yields 0.
  - All-ones operands must propagate the carry correctly.

Test Plan:
- Reset: rst_n low, asserted mid-cycle and asynchronously, during RUN -> busy=0, done=0, product=0 immediately; after release, no done is seen without a new start.
- a=0x12, b=0x95, start pulse -> busy for 8 cycles, done one cycle later, product=0x0A7A; product held afterwards.
- a=0xD2, b=0x95 -> product=0x7A3A; a=0xFF, b=0xFF -> product=0xFE01 (carry-out path exercised).
- a=0x01, b=0xFF, then a=0x00, b=0xB7 back-to-back with start held high -> product=0x00FF, then 0x0000; second start accepted only after DONE→IDLE; operands changed during busy have no effect.
- start pulsed during RUN with different operands -> ignored; result matches the original operands; exactly one done pulse per accepted start.
